// File: rtl/pwm_bank.sv
// pwm_bank: bank of NUM_CH PWM channels that share one prescaler and one period counter.
// Duty and prescale writes go to shadow registers. The active copies load from the
// shadows at each period boundary, and also on the first enabled cycle after ena was low.
//
// Ports:
//   clk          single clock; all state changes on its rising edge
//   rst_n        asynchronous active-low reset
//   ena          global enable; while low the counters are held at 0 and the outputs are 0
//   wr_en        register write strobe
//   wr_addr      0x00 mask, 0x01 prescale, 0x02+i duty shadow of channel i
//   wr_data      write data (only the low bits of each field are kept)
//   pwm_out      registered PWM outputs; bit i is channel i
//   period_tick  one-cycle pulse on the cycle after each period boundary
module pwm_bank #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned PRE_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wr_en,
  input  logic [7:0]        wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              run;
  logic [NUM_CH-1:0] mask;
  logic [PRE_W-1:0]  pre_sh;
  logic [PRE_W-1:0]  pre_act;
  logic [PRE_W-1:0]  pre_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  duty_sh  [NUM_CH];
  logic [CNT_W-1:0]  duty_act [NUM_CH];

  logic              start;
  logic              step;
  logic              boundary;
  logic [PRE_W-1:0]  eff_pre;
  logic [CNT_W-1:0]  eff_duty [NUM_CH];
  logic [NUM_CH-1:0] pwm_nxt;

  // On the first enabled cycle, the shadows act as the active values right away.
  // This lets counting start at cnt=0 on that same cycle.
  always_comb begin
    start    = ena & ~run;
    eff_pre  = start ? pre_sh : pre_act;
    step     = ena & (pre_cnt == eff_pre);
    boundary = step & ~start & (cnt == CNT_MAX);
    pwm_nxt  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      eff_duty[i] = start ? duty_sh[i] : duty_act[i];
      pwm_nxt[i]  = ena & mask[i] & ((eff_duty[i] == CNT_MAX) | (cnt < eff_duty[i]));
    end
  end

  // Register writes. They are accepted whether or not ena is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask   <= '0;
      pre_sh <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_sh[i] <= '0;
    end else if (wr_en) begin
      if (wr_addr == 8'h00) mask   <= NUM_CH'(wr_data);
      if (wr_addr == 8'h01) pre_sh <= PRE_W'(wr_data);
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_addr == 8'(i + 2)) duty_sh[i] <= wr_data;
      end
    end
  end

  // Prescaler, period counter, active-copy loads and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      pre_act     <= '0;
      pre_cnt     <= '0;
      cnt         <= '0;
      pwm_out     <= '0;
      period_tick <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) duty_act[i] <= '0;
    end else if (!ena) begin
      run         <= 1'b0;
      pre_cnt     <= '0;
      cnt         <= '0;
      pwm_out     <= '0;
      period_tick <= 1'b0;
    end else begin
      run         <= 1'b1;
      pre_cnt     <= step ? '0 : pre_cnt + PRE_W'(1);
      cnt         <= step ? cnt + CNT_W'(1) : cnt;
      pwm_out     <= pwm_nxt;
      period_tick <= boundary;
      if (start || boundary) begin
        pre_act <= pre_sh;
        for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_sh[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank (NUM_CH=8, CNT_W=8, PRE_W=4). Expected values are derived from the
// period-level rules of the block: one period lasts 256*(prescale+1) cycles. A channel is
// high for duty*(prescale+1) of those cycles; duty 0xFF keeps it high for the whole period
// and a cleared mask bit keeps it low. Each period is measured from one period_tick to the
// next.
module tb_pwm_bank;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PRE_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              wr_en;
  logic [7:0]        wr_addr;
  logic [CNT_W-1:0]  wr_data;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_tick;

  int checks = 0;
  int errors = 0;

  int per_len;
  int hi_cnt [NUM_CH];
  bit per_ok;

  pwm_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .pwm_out(pwm_out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  // Single register write; called at a negedge and returns at the next negedge.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
  endtask

  // Count cycles and per-channel high cycles up to and including the next period_tick.
  task automatic measure(input string name);
    per_len = 0; per_ok = 1'b0;
    for (int i = 0; i < NUM_CH; i++) hi_cnt[i] = 0;
    while (per_len < 5000) begin
      @(negedge clk);
      per_len++;
      for (int i = 0; i < NUM_CH; i++) if (pwm_out[i]) hi_cnt[i]++;
      if (period_tick) begin per_ok = 1'b1; break; end
    end
    checks++;
    if (!per_ok) begin
      errors++;
      $display("FAIL %s tick_timeout got no tick within %0d cycles", name, per_len);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; wr_en = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (pwm_out !== 8'h00 || period_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got pwm=%h tick=%b want pwm=00 tick=0", pwm_out, period_tick);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    wr(8'h00, 8'h01); wr(8'h02, 8'h40); wr(8'h01, 8'h00);
    ena = 1'b1;
    for (int p = 0; p < 2; p++) begin
      measure("basic");
      checks++;
      if (per_len != 256 || hi_cnt[0] != 64) begin
        errors++;
        $display("FAIL basic_period%0d got len=%0d high=%0d want len=256 high=64", p, per_len, hi_cnt[0]);
      end
    end
  endtask

  task automatic test_extremes();
    wr(8'h02, 8'h00); wr(8'h03, 8'hFF); wr(8'h00, 8'h03);
    measure("extremes_sync");
    for (int p = 0; p < 3; p++) begin
      measure("extremes");
      checks++;
      if (per_len != 256 || hi_cnt[0] != 0 || hi_cnt[1] != 256) begin
        errors++;
        $display("FAIL extremes_period%0d got len=%0d ch0_high=%0d ch1_high=%0d want 256 0 256",
                 p, per_len, hi_cnt[0], hi_cnt[1]);
      end
    end
  endtask

  task automatic test_prescale();
    int pre_part;
    wr(8'h02, 8'h80); wr(8'h01, 8'h03); wr(8'h00, 8'h01);
    measure("prescale_sync");
    measure("prescale_full");
    checks++;
    if (per_len != 1024 || hi_cnt[0] != 512) begin
      errors++;
      $display("FAIL prescale_full got len=%0d high=%0d want len=1024 high=512", per_len, hi_cnt[0]);
    end
    repeat (300) @(negedge clk);
    wr(8'h01, 8'h00);
    pre_part = 301;
    measure("prescale_mid");
    checks++;
    if (pre_part + per_len != 1024) begin
      errors++;
      $display("FAIL prescale_midwrite got len=%0d want len=1024", pre_part + per_len);
    end
    measure("prescale_after");
    checks++;
    if (per_len != 256 || hi_cnt[0] != 128) begin
      errors++;
      $display("FAIL prescale_after got len=%0d high=%0d want len=256 high=128", per_len, hi_cnt[0]);
    end
  endtask

  task automatic test_boundary_write();
    wr(8'h02, 8'h10);
    measure("bwrite_sync");
    repeat (255) @(negedge clk);
    wr_en = 1'b1; wr_addr = 8'h02; wr_data = 8'h20;
    @(negedge clk);
    wr_en = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
    checks++;
    if (period_tick !== 1'b1) begin
      errors++;
      $display("FAIL bwrite_on_boundary got tick=%b want tick=1", period_tick);
    end
    measure("bwrite_next");
    checks++;
    if (per_len != 256 || hi_cnt[0] != 16) begin
      errors++;
      $display("FAIL bwrite_next got len=%0d high=%0d want len=256 high=16", per_len, hi_cnt[0]);
    end
    measure("bwrite_after");
    checks++;
    if (per_len != 256 || hi_cnt[0] != 32) begin
      errors++;
      $display("FAIL bwrite_after got len=%0d high=%0d want len=256 high=32", per_len, hi_cnt[0]);
    end
  endtask

  task automatic test_ena();
    int seen_hi;
    int seen_tick;
    repeat (20) @(negedge clk);
    checks++;
    if (pwm_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL ena_before_drop got pwm0=%b want 1", pwm_out[0]);
    end
    ena = 1'b0;
    @(negedge clk);
    checks++;
    if (pwm_out !== 8'h00 || period_tick !== 1'b0) begin
      errors++;
      $display("FAIL ena_drop got pwm=%h tick=%b want pwm=00 tick=0", pwm_out, period_tick);
    end
    wr(8'h02, 8'h30);
    seen_hi = 0; seen_tick = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (pwm_out != 8'h00) seen_hi++;
      if (period_tick) seen_tick++;
    end
    checks++;
    if (seen_hi != 0 || seen_tick != 0) begin
      errors++;
      $display("FAIL ena_low_idle got active_cycles=%0d ticks=%0d want 0 0", seen_hi, seen_tick);
    end
    ena = 1'b1;
    measure("ena_restart");
    checks++;
    if (per_len != 256 || hi_cnt[0] != 48) begin
      errors++;
      $display("FAIL ena_restart got len=%0d high=%0d want len=256 high=48", per_len, hi_cnt[0]);
    end
  endtask

  task automatic test_async_reset();
    int any_hi;
    repeat (5) @(negedge clk);
    checks++;
    if (pwm_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL areset_before got pwm0=%b want 1", pwm_out[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== 8'h00 || period_tick !== 1'b0) begin
      errors++;
      $display("FAIL areset_async got pwm=%h tick=%b want pwm=00 tick=0", pwm_out, period_tick);
    end
    ena = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wr(8'h0A, 8'hFF);
    any_hi = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pwm_out != 8'h00 || period_tick) any_hi++;
    end
    checks++;
    if (any_hi != 0) begin
      errors++;
      $display("FAIL areset_idle got active_cycles=%0d want 0", any_hi);
    end
    wr(8'h00, 8'hFF);
    ena = 1'b1;
    measure("areset_cleared");
    any_hi = 0;
    for (int i = 0; i < NUM_CH; i++) any_hi += hi_cnt[i];
    checks++;
    if (per_len != 256 || any_hi != 0) begin
      errors++;
      $display("FAIL areset_cleared got len=%0d total_high=%0d want len=256 total_high=0", per_len, any_hi);
    end
  endtask

  task automatic test_random();
    int pre;
    int exp_len;
    int exp_hi;
    logic [7:0] m;
    logic [7:0] pw;
    logic [7:0] d [NUM_CH];
    for (int it = 0; it < 4; it++) begin
      pre = int'($urandom_range(0, 3));
      m = 8'($urandom);
      for (int i = 0; i < NUM_CH; i++) d[i] = 8'($urandom);
      if (it == 0) begin d[0] = 8'h00; d[1] = 8'hFF; m = m | 8'h03; end
      pw = {4'($urandom), 4'(pre)};
      wr(8'h01, pw);
      for (int i = 0; i < NUM_CH; i++) wr(8'(i + 2), d[i]);
      wr(8'h00, m);
      measure("random_sync");
      measure("random");
      exp_len = 256 * (pre + 1);
      checks++;
      if (per_len != exp_len) begin
        errors++;
        $display("FAIL random%0d_len got %0d want %0d", it, per_len, exp_len);
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (!m[i]) exp_hi = 0;
        else if (d[i] == 8'hFF) exp_hi = exp_len;
        else exp_hi = int'(d[i]) * (pre + 1);
        checks++;
        if (hi_cnt[i] != exp_hi) begin
          errors++;
          $display("FAIL random%0d_ch%0d_high got %0d want %0d (duty=%h mask=%b pre=%0d)",
                   it, i, hi_cnt[i], exp_hi, d[i], m[i], pre);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_prescale();
    test_boundary_write();
    test_ena();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
- REQ-001: Parameter NUM_CH, default 8, number of PWM channels (1..CNT_W).
- REQ-002: Parameter CNT_W, default 8, width of period counter and duty registers (4..16).
- REQ-003: Parameter PRE_W, default 4, width of clock prescaler.
- REQ-004: clk  input  1  single clock, all state on rising edge.
- REQ-005: rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-006: ena  input  1  global enable; high = counting.
- REQ-007: wr_en  input  1  register write strobe, one write per cycle high.
- REQ-008: wr_addr  input  8  register address.
- REQ-009: wr_data  input  CNT_W  write data.
- REQ-010: pwm_out  output  NUM_CH  registered PWM outputs, bit i = channel i.
- REQ-011: period_tick  output  1  one-cycle pulse at each period boundary.

Function
- REQ-012: Register map SHALL be: 0x00 channel enable mask (wr_data[NUM_CH-1:0]); 0x01 prescale (wr_data[PRE_W-1:0]); 0x02+i duty shadow of channel i, i < NUM_CH; other addresses ignored, no state change.
- REQ-013: Enable mask SHALL take effect the cycle after the write.
- REQ-014: Duty and prescale writes SHALL go to shadow registers only; active copies load from shadows at a period boundary.
- REQ-015: Prescaler pre_cnt SHALL count 0..prescale_active; a step occurs on a cycle where ena=1 and pre_cnt == prescale_active, and pre_cnt returns to 0 on that cycle.
- REQ-016: Period counter cnt (CNT_W bits) SHALL increment by 1 on each step, wrapping from 2^CNT_W-1 to 0; period = 2^CNT_W*(prescale+1) clk cycles.
- REQ-017: Period boundary = step while cnt == 2^CNT_W-1; on that edge all active duties and prescale_active load from shadows and period_tick is 1 for the next cycle only.
- REQ-018: A shadow write in the same cycle as a boundary SHALL NOT be seen by that load; it takes effect at the following boundary.
- REQ-019: pwm_out[i] SHALL register (ena & mask[i] & (duty_i == 2^CNT_W-1 | cnt < duty_i)), using cnt before that edge's update: duty 0 = always low, duty all-ones = always high, otherwise high for duty_i of 2^CNT_W counts.
- REQ-020: While ena=0: pre_cnt and cnt SHALL hold at 0, pwm_out = 0, period_tick = 0, register writes still accepted.
- REQ-021: On the first cycle ena is sampled 1 after being 0, active duties and prescale SHALL load from shadows (no period_tick) and counting starts from cnt=0.
- REQ-022: Deassertion of ena mid-period SHALL clear pre_cnt and cnt to 0 on the next edge; active duties retain values.
- REQ-023: Out-of-range prescale/duty bits beyond declared widths SHALL be discarded.

Reset
- REQ-024: rst_n low SHALL immediately clear pwm_out, period_tick, cnt, pre_cnt, mask, all shadow and active duties, and shadow/active prescale to 0, regardless of clk.
- REQ-025: Reset asserted mid-period SHALL abandon the period; after release, behaviour SHALL match power-up, with no tick and no outputs until reprogrammed.
- REQ-026: Reset release SHALL be synchronised externally; the block requires no cycles after release before accepting writes.

Verification (NUM_CH=8, CNT_W=8, PRE_W=4)
- REQ-027: Reset, write mask 0x01, duty0=0x40, prescale 0, ena=1 -> pwm_out[0] high exactly 64 of every 256 cycles; period_tick every 256 cycles.
- REQ-028: duty0=0x00 and duty1=0xFF, mask 0x03 -> pwm_out[0] constant 0, pwm_out[1] constant 1 across 3 periods.
- REQ-029: Prescale 3, duty0=0x80 -> period 1024 cycles, high 512; prescale write mid-period changes period length only after the next tick.
- REQ-030: duty0 written 0x20 on the exact boundary cycle, old value 0x10 -> next period high 16 counts, period after high 32.
- REQ-031: ena dropped mid-period -> pwm_out 0 next cycle, counters 0; ena re-raised -> shadow duties active immediately, count restarts at 0.
- REQ-032: rst_n pulsed low between edges mid-period -> all outputs 0 asynchronously; writes to 0x0A (invalid) -> no observable change.
